// File: rtl/tlc_pkg.sv
// Shared types and constants for the main/side-street traffic-light sequencer.
// Holds the phase enum, interval-select codes and the lamp pattern for each phase.
package tlc_pkg;

   typedef enum logic [2:0] {
      MAIN_G1 = 3'd0,
      MAIN_G2 = 3'd1,
      MAIN_Y  = 3'd2,
      WALK    = 3'd3,
      SIDE_G1 = 3'd4,
      SIDE_G2 = 3'd5,
      SIDE_Y  = 3'd6
   } state_t;

   localparam logic [1:0] SEL_BASE = 2'b00;
   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_YEL  = 2'b10;

   // Lamp order: {main_R, main_Y, main_G, side_R, side_Y, side_G, walk}
   localparam logic [6:0] LED_MAIN_G1 = 7'b0010100;
   localparam logic [6:0] LED_MAIN_G2 = 7'b0010100;
   localparam logic [6:0] LED_MAIN_Y  = 7'b0100100;
   localparam logic [6:0] LED_WALK    = 7'b1001001;
   localparam logic [6:0] LED_SIDE_G1 = 7'b1000010;
   localparam logic [6:0] LED_SIDE_G2 = 7'b1000010;
   localparam logic [6:0] LED_SIDE_Y  = 7'b1000100;

   function automatic logic [6:0] lamps_of(input state_t s);
      logic [6:0] lamps;
      lamps = LED_MAIN_G1;
      case (s)
         MAIN_G1: lamps = LED_MAIN_G1;
         MAIN_G2: lamps = LED_MAIN_G2;
         MAIN_Y:  lamps = LED_MAIN_Y;
         WALK:    lamps = LED_WALK;
         SIDE_G1: lamps = LED_SIDE_G1;
         SIDE_G2: lamps = LED_SIDE_G2;
         SIDE_Y:  lamps = LED_SIDE_Y;
         default: lamps = LED_MAIN_G1;
      endcase
      return lamps;
   endfunction

endpackage

// File: rtl/traffic_light_fsm.sv
// Traffic-light phase sequencer: steps through the phases on timer expiry and
// registers lamps, interval select and the timer-start / walk-clear pulses.
module traffic_light_fsm
   import tlc_pkg::*;
(
   input  logic       clk,
   input  logic       Reset_Sync,
   input  logic       Sensor_Sync,
   input  logic       WR,
   input  logic       Prog_Sync,
   input  logic       expired,
   output logic       WR_Reset,
   output logic [6:0] LEDs,
   output logic [1:0] time_selector,
   output logic       start_timer
);

   state_t     state_reg, state_next;
   logic [1:0] sel_reg, sel_next;
   logic [6:0] leds_reg, leds_next;
   logic       start_reg, start_next;
   logic       wr_reset_reg, wr_reset_next;
   logic       init_reg;
   logic       enter;
   logic       advance;

   // The timer is restarting whenever start_timer is high, so expiry is ignored then.
   assign advance = expired && !start_reg;

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      enter      = 1'b0;
      if (Prog_Sync || init_reg) begin
         state_next = MAIN_G1;
         sel_next   = SEL_BASE;
         enter      = 1'b1;
      end else begin
         case (state_reg)
            MAIN_G1: if (advance) begin
               state_next = MAIN_G2;
               sel_next   = Sensor_Sync ? SEL_EXT : SEL_BASE;
               enter      = 1'b1;
            end
            MAIN_G2: if (advance) begin
               state_next = MAIN_Y;
               sel_next   = SEL_YEL;
               enter      = 1'b1;
            end
            MAIN_Y: if (advance) begin
               state_next = WR ? WALK : SIDE_G1;
               sel_next   = WR ? SEL_EXT : SEL_BASE;
               enter      = 1'b1;
            end
            WALK: if (advance) begin
               state_next = SIDE_G1;
               sel_next   = SEL_BASE;
               enter      = 1'b1;
            end
            SIDE_G1: if (advance) begin
               state_next = Sensor_Sync ? SIDE_G2 : SIDE_Y;
               sel_next   = Sensor_Sync ? SEL_EXT : SEL_YEL;
               enter      = 1'b1;
            end
            SIDE_G2: if (advance) begin
               state_next = SIDE_Y;
               sel_next   = SEL_YEL;
               enter      = 1'b1;
            end
            SIDE_Y: if (advance) begin
               state_next = MAIN_G1;
               sel_next   = SEL_BASE;
               enter      = 1'b1;
            end
            default: begin
               state_next = MAIN_G1;
               sel_next   = SEL_BASE;
               enter      = 1'b1;
            end
         endcase
      end
      leds_next     = enter ? lamps_of(state_next) : leds_reg;
      start_next    = enter;
      wr_reset_next = enter && (state_next == WALK);
   end

   always_ff @(posedge clk or negedge Reset_Sync) begin
      if (!Reset_Sync) begin
         state_reg    <= MAIN_G1;
         sel_reg      <= SEL_BASE;
         leds_reg     <= LED_MAIN_G1;
         start_reg    <= 1'b0;
         wr_reset_reg <= 1'b0;
         init_reg     <= 1'b1;
      end else begin
         state_reg    <= state_next;
         sel_reg      <= sel_next;
         leds_reg     <= leds_next;
         start_reg    <= start_next;
         wr_reset_reg <= wr_reset_next;
         init_reg     <= 1'b0;
      end
   end

   assign LEDs          = leds_reg;
   assign time_selector = sel_reg;
   assign start_timer   = start_reg;
   assign WR_Reset      = wr_reset_reg;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed and randomized bench for traffic_light_fsm, checked against a
// phase-name reference model built from the phase table.
module tb_traffic_light_fsm;

   logic       clk = 1'b0;
   logic       Reset_Sync;
   logic       Sensor_Sync;
   logic       WR;
   logic       Prog_Sync;
   logic       expired;
   logic       WR_Reset;
   logic [6:0] LEDs;
   logic [1:0] time_selector;
   logic       start_timer;

   int checks = 0;
   int errors = 0;

   traffic_light_fsm dut (
      .clk           (clk),
      .Reset_Sync    (Reset_Sync),
      .Sensor_Sync   (Sensor_Sync),
      .WR            (WR),
      .Prog_Sync     (Prog_Sync),
      .expired       (expired),
      .WR_Reset      (WR_Reset),
      .LEDs          (LEDs),
      .time_selector (time_selector),
      .start_timer   (start_timer)
   );

   always #5 clk = ~clk;

   // Reference model: current phase by name plus the outputs it should show.
   logic [6:0] lamp_tab[string];
   logic [1:0] sel_tab[string];
   string      m_phase;
   logic [6:0] m_leds;
   logic [1:0] m_sel;
   logic       m_start;
   logic       m_wrr;
   logic       m_first;

   task automatic model_reset();
      m_phase = "MAIN_G1";
      m_leds  = 7'b0010100;
      m_sel   = 2'b00;
      m_start = 1'b0;
      m_wrr   = 1'b0;
      m_first = 1'b1;
   endtask

   task automatic model_enter(input string p);
      m_phase = p;
      m_leds  = lamp_tab[p];
      m_sel   = sel_tab[p];
      if (p == "MAIN_G2")
         m_sel = Sensor_Sync ? 2'b01 : 2'b00;
      m_start = 1'b1;
      m_wrr   = (p == "WALK");
   endtask

   function automatic string successor(input string p);
      case (p)
         "MAIN_G1": return "MAIN_G2";
         "MAIN_G2": return "MAIN_Y";
         "MAIN_Y":  return WR ? "WALK" : "SIDE_G1";
         "WALK":    return "SIDE_G1";
         "SIDE_G1": return Sensor_Sync ? "SIDE_G2" : "SIDE_Y";
         "SIDE_G2": return "SIDE_Y";
         default:   return "MAIN_G1";
      endcase
   endfunction

   task automatic model_edge();
      if (Prog_Sync || m_first)
         model_enter("MAIN_G1");
      else if (expired && !m_start)
         model_enter(successor(m_phase));
      else begin
         m_start = 1'b0;
         m_wrr   = 1'b0;
      end
      m_first = 1'b0;
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (LEDs === m_leds) else begin
         errors++;
         $error("FAIL %s/%s LEDs got %b want %b", tag, m_phase, LEDs, m_leds);
      end
      checks++;
      assert (time_selector === m_sel) else begin
         errors++;
         $error("FAIL %s/%s time_selector got %b want %b", tag, m_phase, time_selector, m_sel);
      end
      checks++;
      assert (start_timer === m_start) else begin
         errors++;
         $error("FAIL %s/%s start_timer got %b want %b", tag, m_phase, start_timer, m_start);
      end
      checks++;
      assert (WR_Reset === m_wrr) else begin
         errors++;
         $error("FAIL %s/%s WR_Reset got %b want %b", tag, m_phase, WR_Reset, m_wrr);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      $display("%0t %s phase=%s LEDs=%b sel=%b start=%b wrr=%b", $time, tag, m_phase,
               LEDs, time_selector, start_timer, WR_Reset);
   endtask

   // Holds expired high until the model enters the target phase, within a cycle budget.
   task automatic go_to(input string target, input string tag);
      int n = 0;
      expired = 1'b1;
      cyc(tag);
      while (m_phase != target && n < 60) begin
         cyc(tag);
         n++;
      end
      checks++;
      assert (m_phase == target) else begin
         errors++;
         $error("FAIL %s timeout reaching %s, at %s", tag, target, m_phase);
      end
      expired = 1'b0;
   endtask

   initial begin
      int pulses;
      lamp_tab["MAIN_G1"] = 7'b0010100; sel_tab["MAIN_G1"] = 2'b00;
      lamp_tab["MAIN_G2"] = 7'b0010100; sel_tab["MAIN_G2"] = 2'b00;
      lamp_tab["MAIN_Y"]  = 7'b0100100; sel_tab["MAIN_Y"]  = 2'b10;
      lamp_tab["WALK"]    = 7'b1001001; sel_tab["WALK"]    = 2'b01;
      lamp_tab["SIDE_G1"] = 7'b1000010; sel_tab["SIDE_G1"] = 2'b00;
      lamp_tab["SIDE_G2"] = 7'b1000010; sel_tab["SIDE_G2"] = 2'b01;
      lamp_tab["SIDE_Y"]  = 7'b1000100; sel_tab["SIDE_Y"]  = 2'b10;

      // Reset held
      Reset_Sync = 1'b0; Sensor_Sync = 1'b0; WR = 1'b0; Prog_Sync = 1'b0; expired = 1'b0;
      model_reset();
      #12;
      check_all("reset_hold");
      #10 Reset_Sync = 1'b1;
      cyc("release");

      // Normal flow: one expired pulse per phase, two idle cycles between
      for (int i = 0; i < 5; i++) begin
         cyc("normal_idle");
         expired = 1'b1;
         cyc("normal_exp");
         expired = 1'b0;
         cyc("normal_idle");
      end

      // Sensor high through a full cycle
      Sensor_Sync = 1'b1;
      for (int i = 0; i < 6; i++) begin
         expired = 1'b1;
         cyc("sensor_exp");
         expired = 1'b0;
         cyc("sensor_idle");
      end

      // Walk request taken at MAIN_Y expiry, then not repeated once cleared
      Sensor_Sync = 1'b0;
      go_to("MAIN_G1", "walk_prep");
      WR = 1'b1;
      cyc("walk_req");
      go_to("WALK", "walk_enter");
      WR = 1'b0;
      cyc("walk_dwell");
      go_to("MAIN_Y", "walk_again");
      cyc("walk_my");
      expired = 1'b1;
      cyc("no_walk");
      expired = 1'b0;
      cyc("no_walk_idle");

      // Prog_Sync from SIDE_G2, alone and together with expired, and held
      Sensor_Sync = 1'b1;
      go_to("SIDE_G2", "prog_prep");
      cyc("prog_dwell");
      Prog_Sync = 1'b1;
      cyc("prog_pulse");
      Prog_Sync = 1'b0;
      go_to("MAIN_G2", "prog_prep2");
      cyc("prog_dwell2");
      Prog_Sync = 1'b1; expired = 1'b1;
      cyc("prog_and_exp");
      cyc("prog_held");
      cyc("prog_held");
      Prog_Sync = 1'b0; expired = 1'b0;
      cyc("prog_release");

      // Expired held high: phase change every other cycle only
      expired = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc("exp_held");
         if (start_timer === 1'b1) pulses++;
      end
      expired = 1'b0;
      checks++;
      assert (pulses === 10) else begin
         errors++;
         $error("FAIL exp_held_pulses got %0d want %0d", pulses, 10);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         Sensor_Sync = 1'($urandom_range(0, 1));
         WR          = 1'($urandom_range(0, 1));
         expired     = 1'($urandom_range(0, 1));
         Prog_Sync   = ($urandom_range(0, 15) == 0);
         cyc("random");
      end
      Prog_Sync = 1'b0; expired = 1'b0; Sensor_Sync = 1'b0;

      // Asynchronous reset from the walk phase, between clock edges
      WR = 1'b1;
      go_to("WALK", "areset_prep");
      #3 Reset_Sync = 1'b0;
      model_reset();
      #1;
      check_all("areset_immediate");
      WR = 1'b0;
      #2 Reset_Sync = 1'b1;
      cyc("areset_release");
      cyc("areset_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Main-street / side-street traffic-light sequencer with a pedestrian walk phase.
- Drives 7 lamp LEDs, selects interval length (time_selector) and pulses start_timer to an external interval timer; advances on that timer's expired pulse.
- Sensor_Sync, WR and Prog_Sync arrive pre-synchronised to clk; the walk-request latch is external and is cleared through WR_Reset.

Parameters:
- None. Interval durations live in the timer block; the FSM only selects them.

Ports:
- clk  input  1  system clock, rising edge.
- Reset_Sync  input  1  asynchronous, active-low reset.
- Sensor_Sync  input  1  main-street traffic sensor, active-high, synchronous.
- WR  input  1  latched walk request, active-high.
- Prog_Sync  input  1  synchronous restart (timer reprogrammed), active-high.
- expired  input  1  timer interval done, sampled at rising edge.
- WR_Reset  output  1  one-cycle pulse that clears the external walk latch.
- LEDs  output  7  lamp bits {main_R, main_Y, main_G, side_R, side_Y, side_G, walk}, bit 6 to bit 0.
- time_selector  output  2  interval select: 00 = BASE, 01 = EXT, 10 = YEL, 11 unused (never driven).
- start_timer  output  1  one-cycle pulse that restarts the timer with the current time_selector.

Behaviour:
- States, with interval, lamps and next state:
  - MAIN_G1: BASE; LEDs 0010100. On expired, go to MAIN_G2.
  - MAIN_G2: EXT if Sensor_Sync = 1 at MAIN_G1 expiry, else BASE; LEDs 0010100. On expired, go to MAIN_Y.
  - MAIN_Y: YEL; LEDs 0100100. On expired, go to WALK if WR = 1, else SIDE_G1.
  - WALK: EXT; LEDs 1001001. On expired, go to SIDE_G1.
  - SIDE_G1: BASE; LEDs 1000010. On expired, go to SIDE_G2 if Sensor_Sync = 1, else SIDE_Y.
  - SIDE_G2: EXT; LEDs 1000010. On expired, go to SIDE_Y.
  - SIDE_Y: YEL; LEDs 1000100. On expired, go to MAIN_G1.
- All outputs are registered.
  - On every state entry, in the same cycle the new state becomes visible: start_timer = 1 for exactly one cycle, time_selector = the new state's code, LEDs = the new lamps.
  - time_selector and LEDs hold for the whole state.
- Latency: expired high at rising edge k gives the new state, LEDs, time_selector and start_timer = 1 in cycle k to k+1.
- expired is ignored in any cycle where start_timer = 1, because the timer is restarting. The FSM therefore dwells at least 2 cycles per state.
- WR_Reset = 1 for exactly one cycle, coincident with start_timer, on entry to WALK. Otherwise WR_Reset = 0.
- WR is sampled only at MAIN_Y expiry. A request asserted during any other state is honoured at the next MAIN_Y expiry.
- Sensor_Sync is sampled only at MAIN_G1 and SIDE_G1 expiry.
- Reset (Reset_Sync = 0, asynchronous):
  - Values while reset is held: state MAIN_G1, LEDs 0010100, time_selector 00, WR_Reset 0, start_timer 0.
  - On the first rising edge after release, start_timer pulses 1 for one cycle to start the BASE interval.
- Prog_Sync = 1 at a rising edge, from any state:
  - Next cycle: MAIN_G1, LEDs 0010100, time_selector 00, start_timer pulses.
  - Prog_Sync has priority over expired.
  - Held Prog_Sync keeps the FSM in MAIN_G1 and re-pulses start_timer every cycle.
- Illegal state encoding recovers to MAIN_G1 with a start_timer pulse.
- Reset asserted mid-state aborts immediately to the reset values; a pending WR_Reset pulse is dropped.

Decomposition:
- Shared package tlc_pkg holds:
  - the state enum;
  - time_selector codes SEL_BASE = 2'b00, SEL_EXT = 2'b01, SEL_YEL = 2'b10;
  - the seven LED pattern constants.
- Single module, no sub-module. The next-state/output decode and the output registers stay in one file.

Test Plan:
- Normal flow, Sensor_Sync = 0, WR = 0:
  - Stimulus: release reset, pulse expired once per state.
  - Required: start_timer at release with time_selector 00; sequence MAIN_G1 (00), MAIN_G2 (00), MAIN_Y (10), SIDE_G1 (00), SIDE_Y (10), MAIN_G1; LEDs per table; WR_Reset stays 0.
- Traffic sensor, Sensor_Sync = 1 from reset:
  - Required: MAIN_G2 has time_selector 01; SIDE_G1 is followed by SIDE_G2 with 01, then SIDE_Y.
- Walk request, WR = 1 during MAIN_G1:
  - Required: MAIN_Y expiry enters WALK with LEDs 1001001, time_selector 01, and start_timer and WR_Reset both high for one cycle.
  - Then WR = 0: next cycle goes MAIN_Y to SIDE_G1 with no WALK.
- Prog_Sync pulse while in SIDE_G2:
  - Required: next cycle MAIN_G1, LEDs 0010100, start_timer = 1.
  - Also: Prog_Sync and expired together resolve to MAIN_G1.
- Expired in a start cycle:
  - Stimulus: expired held high continuously.
  - Required: state advances every 2 cycles, never every cycle; start_timer alternates 1/0.
- Asynchronous reset from WALK:
  - Stimulus: drop Reset_Sync between clock edges.
  - Required: LEDs 0010100, WR_Reset 0 and start_timer 0 immediately without a clock edge; start_timer pulses on the first edge after release.
